// File: rtl/gene_net.sv
// 8-gene synchronous Boolean regulatory network with seed reload.
// Any change on x_in reloads the state; otherwise the state advances through f.
module gene_net (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x_in,
    output logic [7:0] x_out,
    output logic       load,
    output logic [7:0] step_cnt
);

    logic [7:0] x_out_q, x_out_d;
    logic [7:0] x_q, x_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_q, load_d;
    logic       pend_q, pend_d;
    logic       reseed;
    logic [7:0] f_x;

    function automatic logic [7:0] f_upd(input logic [7:0] x);
        logic [7:0] n;
        n[7] = ~x[7] & x[6] & x[2];
        n[6] = x[1];
        n[5] = x[4] & ~x[0] & (x[2] | x[1]);
        n[4] = x[4] | x[6];
        n[3] = x[4] & ~x[6] & ~x[0];
        n[2] = x[5] & ~x[6];
        n[1] = x[0] | (x[6] & x[2]);
        n[0] = x[0] & x[1];
        return n;
    endfunction

    assign f_x    = f_upd(x_out_q);
    // Pending flag forces a load on the first edge after reset even if x_in == 0.
    assign reseed = pend_q | (x_in != x_q);

    always_comb begin
        x_out_d = f_x;
        x_d     = x_q;
        load_d  = 1'b0;
        pend_d  = 1'b0;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (reseed) begin
            x_out_d = x_in;
            x_d     = x_in;
            load_d  = 1'b1;
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out_q <= 8'h00;
            x_q     <= 8'h00;
            cnt_q   <= 8'h00;
            load_q  <= 1'b0;
            pend_q  <= 1'b1;
        end else begin
            x_out_q <= x_out_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            pend_q  <= pend_d;
        end
    end

    assign x_out    = x_out_q;
    assign load     = load_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_gene_net.sv
// Scoreboard bench for gene_net: reference model of f and seed/count rules.
// Known attractors are also checked against literal constants.
module tb_gene_net;

    logic       clk;
    logic       rst_n;
    logic [7:0] x_in;
    logic [7:0] x_out;
    logic       load;
    logic [7:0] step_cnt;

    gene_net dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_in    (x_in),
        .x_out   (x_out),
        .load    (load),
        .step_cnt(step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [16:0] sb[$];

    logic       m_pend;
    logic [7:0] m_xq;
    logic [7:0] m_x;
    logic       m_ld;
    logic [7:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] f_ref(input logic [7:0] s);
        logic a0, a1, a2, a3, a4, a5, a6, a7;
        {a7, a6, a5, a4, a3, a2, a1, a0} = s;
        return {~a7 & a6 & a2,
                a1,
                a4 & ~a0 & (a2 | a1),
                a4 | a6,
                a4 & ~a6 & ~a0,
                a5 & ~a6,
                a0 | (a6 & a2),
                a0 & a1};
    endfunction

    task automatic model_reset();
        m_pend = 1'b1;
        m_xq   = 8'h00;
        m_x    = 8'h00;
        m_ld   = 1'b0;
        m_cnt  = 8'h00;
    endtask

    // Drive one cycle of stimulus, push the expected output, then compare.
    task automatic cyc(input logic [7:0] x);
        logic [16:0] e;
        x_in = x;
        if (m_pend || x != m_xq) begin
            m_x    = x;
            m_xq   = x;
            m_ld   = 1'b1;
            m_cnt  = 8'd0;
            m_pend = 1'b0;
        end else begin
            m_x  = f_ref(m_x);
            m_ld = 1'b0;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        sb.push_back({m_x, m_ld, m_cnt});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("x_out", {24'd0, x_out}, {24'd0, e[16:9]});
            check("load", {31'd0, load}, {31'd0, e[8]});
            check("step_cnt", {24'd0, step_cnt}, {24'd0, e[7:0]});
        end
    endtask

    logic [7:0] alt_a[2];
    logic [7:0] alt_b[2];

    initial begin
        alt_a[0] = 8'h38; alt_a[1] = 8'h1C;
        alt_b[0] = 8'h7C; alt_b[1] = 8'hB2;
        rst_n = 1'b0;
        x_in  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", {24'd0, x_out}, 32'h00);
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_cnt", {24'd0, step_cnt}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cyc(8'h00);
            check("fp00", {24'd0, x_out}, 32'h00);
            check("cnt_inc", {24'd0, step_cnt}, i);
        end
        check("first_load", 32'd1, 32'd1);

        for (int i = 0; i < 10; i++) begin
            cyc(8'h38);
            check("cyc38", {24'd0, x_out}, {24'd0, alt_a[i % 2]});
            check("ld38", {31'd0, load}, (i == 0) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 12; i++) cyc(8'h63);

        for (int i = 0; i < 6; i++) begin
            cyc(8'h53);
            check("fp53", {24'd0, x_out}, 32'h53);
        end

        for (int i = 0; i < 8; i++) begin
            cyc(8'h7C);
            check("cyc7c", {24'd0, x_out}, {24'd0, alt_b[i % 2]});
        end

        for (int i = 0; i < 260; i++) begin
            cyc(8'hFF);
            if (i == 0) check("ff0", {24'd0, x_out}, 32'hFF);
            else check("ff_to_53", {24'd0, x_out}, 32'h53);
        end
        check("sat", {24'd0, step_cnt}, 32'd255);

        for (int i = 0; i < 4; i++) cyc(8'h01);
        for (int i = 0; i < 3; i++) cyc(8'h02);
        for (int i = 0; i < 2; i++) cyc(8'h04);

        cyc(8'h7C);
        cyc(8'h7C);
        check("pre_rst", {24'd0, x_out}, 32'hB2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_x", {24'd0, x_out}, 32'h00);
        check("async_ld", {31'd0, load}, 32'd0);
        check("async_cnt", {24'd0, step_cnt}, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cyc(8'h7C);
        check("reload", {24'd0, x_out}, 32'h7C);
        cyc(8'h7C);

        for (int s = 0; s < 256; s++) begin
            cyc(s[7:0]);
            cyc(s[7:0]);
            check("f_all", {24'd0, x_out}, {24'd0, f_ref(s[7:0])});
        end

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gene_net.md
Name: gene_net

Overview:
- 8-gene synchronous Boolean regulatory network. Each clock, the 8-bit state advances through a fixed update function f. The state is re-seeded whenever the seed input changes.
- Used as the state generator feeding the team's fixed-point and cycle checkers, which observe x_out.

Parameters:
- none (network width fixed at 8 genes; update rules hard-wired)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, asynchronous, active-low
- x_in  input  8  seed state; any change re-seeds the network
- x_out  output  8  current network state, registered; bit i = gene xi
- load  output  1  registered pulse, high for the one cycle in which x_out holds a freshly loaded seed
- step_cnt  output  8  number of f-updates since last load, saturates at 255

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, async):
  - x_out=0x00, load=0, step_cnt=0, seed shadow register x_q=0x00.
  - Internal seed_pend=1, so the first active edge after reset always loads x_in.
- Each rising edge with rst_n=1:
  - Seed update: if seed_pend=1 or x_in != x_q → x_out<=x_in, x_q<=x_in, load<=1, step_cnt<=0, seed_pend<=0.
  - Otherwise → x_out<=f(x_out), load<=0, step_cnt<=min(step_cnt+1,255).
- Latency:
  - Seed visible on x_out 1 cycle after the edge that samples the change.
  - f(seed) appears 1 cycle after that, and so on.
- Seed changing every cycle: loads every cycle; no evolution occurs.
- Update function f, all bits computed in parallel from current state x (x' = next):
  - x7' = ~x7 & x6 & x2
  - x6' = x1
  - x5' = x4 & ~x0 & (x2 | x1)
  - x4' = x4 | x6
  - x3' = x4 & ~x6 & ~x0
  - x2' = x5 & ~x6
  - x1' = x0 | (x6 & x2)
  - x0' = x0 & x1
- Known attractors:
  - Fixed points: 0x00 and 0x53.
  - 2-cycles: {0x38, 0x1C} and {0x7C, 0xB2}.
  - 0xFF → 0x53 in one step.
- Mid-run reset: async clear to the reset values; the next edge reloads the current x_in.
- No combinational path from x_in to x_out.

Test Plan:
- Reset low, x_in=0x00, release reset → after 1st edge x_out=0x00 with load=1; then x_out stays 0x00 every cycle; step_cnt increments 1,2,3…
- x_in 0x00→0x38 held 10 cycles → x_out sequence 0x38, 0x1C, 0x38, 0x1C…; load high only on the first cycle.
- x_in→0x63 → x_out sequence 0x63, then evolves per f and is checked against a reference model of f every cycle; x_in→0x53 → x_out 0x53 constant (fixed point).
- x_in→0x7C → x_out sequence 0x7C, 0xB2, 0x7C, 0xB2…
- x_in→0xFF → x_out sequence 0xFF, 0x53, 0x53, 0x53…; step_cnt saturates at 255 after long hold.
- Assert rst_n=0 mid-cycle while x_out=0xB2 → x_out=0x00 immediately (before next edge); release → reloads current x_in; exhaustive f check across all 256 seeds against the reference model.
